// File: rtl/serial_adder.sv
// Bit-serial adder: a single full_adder slice with a registered carry, one bit
// per clock LSB first, operands in and result out over valid/ready handshakes.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (ra[0]),
    .b     (rb[0]),
    .cin   (c),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = SHIFT;
        else          state_next = IDLE;
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
        else             state_next = SHIFT;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Serial datapath; the result registers capture only on the final bit so
  // they hold steady through DONE and keep the last result while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra   <= {WIDTH{1'b0}};
      rb   <= {WIDTH{1'b0}};
      rs   <= {WIDTH{1'b0}};
      c    <= 1'b0;
      cnt  <= {CW{1'b0}};
      sum  <= {WIDTH{1'b0}};
      cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra  <= a;
            rb  <= b;
            c   <= cin;
            cnt <= {CW{1'b0}};
          end
        end
        SHIFT: begin
          c   <= fa_carry;
          rs  <= {fa_sum, rs[WIDTH-1:1]};
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum  <= {fa_sum, rs[WIDTH-1:1]};
            cout <= fa_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder that computes the sum with one `full_adder` cell and a registered carry. It processes one bit per clock, LSB first, and keeps area at a single adder slice. It sits directly upstream of the result consumer and drives the existing `full_adder` cell's `a`/`b`/`cin` inputs, taking back its `sum`/`carry`. Operands arrive and results leave through valid/ready handshakes.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands `a`, `b`, `cin` are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  `sum`/`cout` hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- Internal registers: shift registers `ra`, `rb`, `rs` (WIDTH each), carry flop `c`, bit counter `cnt` of ceil(log2(WIDTH)) bits.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`=1: load `ra`<=`a`, `rb`<=`b`, `c`<=`cin`, `cnt`<=0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle the full_adder is driven with (`ra[0]`, `rb[0]`, `c`).
  - Updates per cycle: `c`<=carry; `rs`<={sum bit, `rs[WIDTH-1:1]`} (shift right, inserting at the MSB); `ra`,`rb` shift right with zero fill; `cnt`<=`cnt`+1.
  - When `cnt`==WIDTH-1, the final bit is written and the state goes to DONE.
  - `in_valid` is ignored in SHIFT, and `in_ready`=0.
- DONE:
  - `out_valid`=1, `sum`=`rs`, `cout`=`c`.
  - Both outputs stay stable until `out_ready`=1, which returns the block to IDLE on that edge.
  - `in_ready`=0 in DONE; there is no overlap of accept and deliver.
- `sum` and `cout` are registered and retain the last result after returning to IDLE. Consumers must only sample them when `out_valid`=1.
- Arithmetic: result is modulo 2^WIDTH; `cout` is the true carry, so {`cout`,`sum`} = a+b+cin exactly.

## Timing
- Reset (`rst`=1 at an edge):
  - state<=IDLE; `rs`, `ra`, `rb`, `c`, `cnt` <= 0.
  - Output values after reset: `out_valid`=0, `in_ready`=1, `sum`=0, `cout`=0.
  - Reset has priority over every other event.
- Reset mid-operation (in SHIFT or DONE): the operation is aborted and no `out_valid` pulse is produced. A new operation may be accepted on the first edge after `rst` falls.
- Accept happens on edge E0, where `in_valid`=1 and `in_ready`=1.
- SHIFT runs for edges E1..E(WIDTH). `out_valid` rises after edge E(WIDTH), giving a latency of WIDTH cycles from acceptance to `out_valid`.
- If `out_ready`=1 already when DONE is entered, the result is delivered on the next edge. IDLE is then held for one cycle.
- Peak throughput is one operation per WIDTH+2 cycles.
- Backpressure: DONE may last any number of cycles. `sum` and `cout` must not change while `out_valid`=1 and `out_ready`=0.
- `in_valid` held high continuously: a new operand is accepted on the first edge in IDLE after each delivery.
- `out_ready` asserted outside DONE has no effect.

## Test plan
- WIDTH=8, a=0x00, b=0x00, cin=0 → `out_valid` exactly 8 cycles after accept, `sum`=0x00, `cout`=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. Carry ripples through all 8 serial steps.
- WIDTH=8, a=0xA5, b=0x5A, cin=1 → `sum`=0x00, `cout`=1. Then a=0x7F, b=0x01, cin=0 back-to-back → `sum`=0x80, `cout`=0, with `in_ready` low throughout SHIFT/DONE.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE with a=0x3C, b=0x0F → `sum`=0x4B and `cout`=0 stay stable, `out_valid` stays high, and `in_ready` stays 0. Release `out_ready` → IDLE on the next edge.
- Reset mid-operation: assert `rst` for one cycle on the 3rd SHIFT cycle → `out_valid` never pulses, `sum`=0, `in_ready`=1 next cycle. The following op 0x12+0x34 gives 0x46.
- WIDTH=4, exhaustive sweep: all 512 (a,b,cin) combinations compared against a+b+cin in the bench model, with random `out_ready` stalls.
